// File: rtl/clksel_ctrl.sv
// clksel_ctrl: speed-request controller for the CPU clock switcher.
// Watches the CPU address bus (sampled on each rising edge of the switched
// CPU clock) and drives the switcher's high-speed select and divider selects.
// Accesses to the I/O window 0xFC00-0xFEFF, or turbo being disabled, force
// low-speed operation. High speed resumes only after HOLD quiet CPU cycles.
//
// Parameters:
//   SETTLE - hsclk_in cycles allowed for a switcher handover (1..31)
//   HOLD   - non-slow CPU cycles required before returning to high speed (0..15)
//
// Ports:
//   hsclk_in       - sole clock, all flops on its rising edge
//   rst            - asynchronous active-high reset
//   cpuclk_in      - switched CPU clock, asynchronous to hsclk_in
//   cpu_addr       - CPU address, stable while cpuclk_in is high
//   cfg_wr         - one-cycle config write strobe
//   cfg_data       - [0] turbo_en, [2:1] hsclk_div_sel, [4:3] cpuclk_div_sel
//   hsclk_sel      - 1 requests the high-speed clock
//   hsclk_div_sel  - high-speed divider select to the switcher
//   cpuclk_div_sel - CPU clock divider select to the switcher
//   slow_active    - 1 while in LSMODE or TOLS
//   busy           - 1 while a handover (TOLS or TOHS) is in progress
module clksel_ctrl #(
  parameter int unsigned SETTLE = 16,
  parameter int unsigned HOLD   = 4
) (
  input  logic        hsclk_in,
  input  logic        rst,
  input  logic        cpuclk_in,
  input  logic [15:0] cpu_addr,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_data,
  output logic        hsclk_sel,
  output logic [1:0]  hsclk_div_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        slow_active,
  output logic        busy
);

  typedef enum logic [1:0] {
    HSMODE,
    TOLS,
    LSMODE,
    TOHS
  } state_e;

  localparam logic [4:0] SETTLE_C = 5'(SETTLE);
  localparam logic [3:0] HOLD_C   = 4'(HOLD);

  state_e     state_q;
  logic       sync1_q, sync2_q, edge_q;
  logic       sample_q, slow_hit_q;
  logic       hsclk_sel_q;
  logic [4:0] settle_q;
  logic [3:0] hold_q;
  logic       pend_slow_q;
  logic [4:0] pend_cfg_q;
  logic       cfg_dirty_q;
  logic       turbo_q;
  logic [1:0] hdiv_q, cdiv_q;

  logic rise_d;
  logic slow_hit_d;
  logic slow_req;
  logic unused_addr_lo;

  // Only the upper address byte takes part in the I/O window decode.
  assign unused_addr_lo = ^cpu_addr[7:0];

  assign rise_d     = sync2_q & ~edge_q;
  assign slow_hit_d = (cpu_addr[15:10] == 6'h3F) & (cpu_addr[15:8] != 8'hFF);
  assign slow_req   = slow_hit_q | ~turbo_q;

  // Synchronizer, edge detect, and address capture. The sample pulse is
  // registered together with the decoded address so the FSM sees both on
  // the same cycle.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      sample_q   <= 1'b0;
      slow_hit_q <= 1'b0;
    end else begin
      sync1_q  <= cpuclk_in;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      sample_q <= rise_d;
      if (rise_d) slow_hit_q <= slow_hit_d;
    end
  end

  // Pending config is applied only while settled in LSMODE; a write landing
  // in the transfer cycle keeps cfg_dirty set so the newer value follows.
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      pend_cfg_q  <= '0;
      cfg_dirty_q <= 1'b0;
      turbo_q     <= 1'b0;
      hdiv_q      <= '0;
      cdiv_q      <= '0;
    end else begin
      if (cfg_wr) pend_cfg_q <= cfg_data;
      if (state_q == LSMODE && cfg_dirty_q) begin
        turbo_q <= pend_cfg_q[0];
        hdiv_q  <= pend_cfg_q[2:1];
        cdiv_q  <= pend_cfg_q[4:3];
      end
      if (cfg_wr) cfg_dirty_q <= 1'b1;
      else if (state_q == LSMODE) cfg_dirty_q <= 1'b0;
    end
  end

  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state_q     <= LSMODE;
      hsclk_sel_q <= 1'b0;
      settle_q    <= '0;
      hold_q      <= '0;
      pend_slow_q <= 1'b0;
    end else begin
      unique case (state_q)
        HSMODE: begin
          if (pend_slow_q || (sample_q && slow_req) || cfg_wr) begin
            state_q     <= TOLS;
            hsclk_sel_q <= 1'b0;
            settle_q    <= SETTLE_C;
            pend_slow_q <= 1'b0;
          end
        end
        TOLS: begin
          if (settle_q == '0) begin
            state_q <= LSMODE;
            hold_q  <= HOLD_C;
          end else begin
            settle_q <= settle_q - 5'd1;
          end
        end
        LSMODE: begin
          // A slow access in the same cycle as the exit check wins, so a
          // just-seen I/O access never rides into the high-speed handover.
          if (sample_q && slow_req) begin
            hold_q <= HOLD_C;
          end else if (hold_q == '0 && turbo_q && !cfg_dirty_q) begin
            state_q     <= TOHS;
            hsclk_sel_q <= 1'b1;
            settle_q    <= SETTLE_C;
          end else if (sample_q && hold_q != '0) begin
            hold_q <= hold_q - 4'd1;
          end
        end
        TOHS: begin
          if (sample_q && slow_req) pend_slow_q <= 1'b1;
          if (settle_q == '0) state_q <= HSMODE;
          else settle_q <= settle_q - 5'd1;
        end
        default: begin
          state_q     <= LSMODE;
          hsclk_sel_q <= 1'b0;
        end
      endcase
    end
  end

  assign hsclk_sel      = hsclk_sel_q;
  assign hsclk_div_sel  = hdiv_q;
  assign cpuclk_div_sel = cdiv_q;
  assign slow_active    = (state_q == LSMODE) || (state_q == TOLS);
  assign busy           = (state_q == TOLS) || (state_q == TOHS);

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed testbench for clksel_ctrl with hand-computed expectations.
// Status word is {hsclk_sel, slow_active, busy}:
//   HSMODE=100, TOHS=101, TOLS=011, LSMODE=010.
module tb_clksel_ctrl;

  logic        hsclk_in;
  logic        rst;
  logic        cpuclk_in;
  logic [15:0] cpu_addr;
  logic        cfg_wr;
  logic [4:0]  cfg_data;
  logic        hsclk_sel;
  logic [1:0]  hsclk_div_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        slow_active;
  logic        busy;

  localparam logic [2:0] ST_HS   = 3'b100;
  localparam logic [2:0] ST_TOHS = 3'b101;
  localparam logic [2:0] ST_TOLS = 3'b011;
  localparam logic [2:0] ST_LS   = 3'b010;

  int unsigned n_pass;
  int unsigned n_total;

  logic [2:0] st;
  assign st = {hsclk_sel, slow_active, busy};

  clksel_ctrl #(.SETTLE(16), .HOLD(4)) dut (
    .hsclk_in       (hsclk_in),
    .rst            (rst),
    .cpuclk_in      (cpuclk_in),
    .cpu_addr       (cpu_addr),
    .cfg_wr         (cfg_wr),
    .cfg_data       (cfg_data),
    .hsclk_sel      (hsclk_sel),
    .hsclk_div_sel  (hsclk_div_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .slow_active    (slow_active),
    .busy           (busy)
  );

  initial begin
    hsclk_in = 1'b0;
    forever #5 hsclk_in = ~hsclk_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge hsclk_in);
    #1;
  endtask

  task automatic cpu_pulse(input logic [15:0] addr);
    cpu_addr  = addr;
    cpuclk_in = 1'b1;
    tick(4);
    cpuclk_in = 1'b0;
    tick(4);
  endtask

  task automatic cfg_write(input logic [4:0] data);
    cfg_data = data;
    cfg_wr   = 1'b1;
    tick(1);
    cfg_wr   = 1'b0;
  endtask

  // From LSMODE with hold=4: four quiet samples, then TOHS for 17 cycles.
  task automatic return_to_hs(input string tag);
    repeat (3) cpu_pulse(16'h1000);
    check_eq({tag, "_ls_hold1"}, 32'(st), 32'(ST_LS));
    cpu_addr  = 16'h1000;
    cpuclk_in = 1'b1;
    tick(4);
    check_eq({tag, "_ls_hold0"}, 32'(st), 32'(ST_LS));
    cpuclk_in = 1'b0;
    tick(1);
    check_eq({tag, "_tohs_entry"}, 32'(st), 32'(ST_TOHS));
    tick(16);
    check_eq({tag, "_tohs_last"}, 32'(st), 32'(ST_TOHS));
    tick(1);
    check_eq({tag, "_hs"}, 32'(st), 32'(ST_HS));
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b0;
    cpuclk_in = 1'b0;
    cpu_addr  = 16'h0000;
    cfg_wr    = 1'b0;
    cfg_data  = 5'b0;

    // Reset
    #1 rst = 1'b1;
    #1;
    check_eq("rst_status", 32'(st), 32'(ST_LS));
    check_eq("rst_hdiv", 32'(hsclk_div_sel), 32'd0);
    check_eq("rst_cdiv", 32'(cpuclk_div_sel), 32'd0);
    @(posedge hsclk_in);
    #3 rst = 1'b0;
    tick(1);
    check_eq("post_rst_status", 32'(st), 32'(ST_LS));

    // Turbo off: a sample counts as slow and loads hold=4
    cpu_pulse(16'h1000);
    check_eq("turbo_off_ls", 32'(st), 32'(ST_LS));

    // Enable turbo; hold still 4 so no immediate exit
    cfg_write(5'b00001);
    tick(3);
    check_eq("turbo_on_hold4", 32'(st), 32'(ST_LS));
    return_to_hs("en");

    // I/O hit from HSMODE: hsclk_sel falls on the 4th edge after the rise
    cpu_addr  = 16'hFE40;
    cpuclk_in = 1'b1;
    tick(3);
    check_eq("io_hs_before", 32'(st), 32'(ST_HS));
    tick(1);
    check_eq("io_tols_entry", 32'(st), 32'(ST_TOLS));
    cpuclk_in = 1'b0;
    tick(16);
    check_eq("io_tols_last", 32'(st), 32'(ST_TOLS));
    tick(1);
    check_eq("io_ls", 32'(st), 32'(ST_LS));

    // Boundary addresses: 0xFFFC and 0xFBFF are quiet, 0xFC00 reloads
    cpu_pulse(16'hFFFC);
    cpu_pulse(16'hFBFF);
    cpu_pulse(16'h1000);
    check_eq("bnd_hold1", 32'(st), 32'(ST_LS));
    cpu_pulse(16'hFC00);
    check_eq("bnd_fc00_reload", 32'(st), 32'(ST_LS));
    return_to_hs("bnd");

    // Config write in HSMODE forces a drop; divs apply only once in LSMODE
    cfg_write(5'b11011);
    check_eq("cfg_tols", 32'(st), 32'(ST_TOLS));
    check_eq("cfg_hdiv_tols", 32'(hsclk_div_sel), 32'd0);
    tick(16);
    check_eq("cfg_tols_last", 32'(st), 32'(ST_TOLS));
    tick(1);
    check_eq("cfg_ls", 32'(st), 32'(ST_LS));
    check_eq("cfg_hdiv_ls_entry", 32'(hsclk_div_sel), 32'd0);
    tick(1);
    check_eq("cfg_hdiv", 32'(hsclk_div_sel), 32'd1);
    check_eq("cfg_cdiv", 32'(cpuclk_div_sel), 32'd3);
    check_eq("cfg_ls_after", 32'(st), 32'(ST_LS));
    return_to_hs("cfg");

    // Slow hit during TOHS: HSMODE lasts one cycle, then TOLS
    cpu_pulse(16'hFE00);
    tick(16);
    check_eq("ph_ls", 32'(st), 32'(ST_LS));
    repeat (3) cpu_pulse(16'h1000);
    cpu_addr  = 16'h1000;
    cpuclk_in = 1'b1;
    tick(4);
    cpuclk_in = 1'b0;
    tick(1);
    check_eq("ph_tohs_entry", 32'(st), 32'(ST_TOHS));
    tick(4);
    cpu_addr  = 16'hFD00;
    cpuclk_in = 1'b1;
    tick(4);
    check_eq("ph_tohs_mid", 32'(st), 32'(ST_TOHS));
    cpuclk_in = 1'b0;
    tick(8);
    check_eq("ph_tohs_last", 32'(st), 32'(ST_TOHS));
    tick(1);
    check_eq("ph_hs_one", 32'(st), 32'(ST_HS));
    tick(1);
    check_eq("ph_tols", 32'(st), 32'(ST_TOLS));
    tick(16);
    check_eq("ph_tols_last", 32'(st), 32'(ST_TOLS));
    tick(1);
    check_eq("ph_ls", 32'(st), 32'(ST_LS));

    // pend_slow must be gone: HSMODE now holds
    return_to_hs("pc");
    tick(3);
    check_eq("pc_hs_stays", 32'(st), 32'(ST_HS));

    // Asynchronous reset in the middle of TOLS
    cpu_addr  = 16'hFE00;
    cpuclk_in = 1'b1;
    tick(4);
    check_eq("ar_tols", 32'(st), 32'(ST_TOLS));
    cpuclk_in = 1'b0;
    tick(3);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_status", 32'(st), 32'(ST_LS));
    check_eq("ar_hdiv", 32'(hsclk_div_sel), 32'd0);
    check_eq("ar_cdiv", 32'(cpuclk_div_sel), 32'd0);
    #1 rst = 1'b0;
    tick(2);
    check_eq("ar_released", 32'(st), 32'(ST_LS));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
